// File: rtl/countdown_timer_pkg.sv
// Shared types and sizing helper for the loadable countdown timer.
// State encoding and prescaler width derivation live here so both modules agree.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A prescaler of 1 still needs a 1-bit register to keep the port legal.
    function automatic int prescaler_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/countdown_prescaler.sv
// Prescaler: emits a combinational tick every PRESCALE enabled cycles; zero latency.
// Holds while enable is low; clear forces the phase back to zero on the next edge.
module countdown_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int PW = prescaler_width(PRESCALE);

    logic [PW-1:0] cnt;

    assign tick = enable && (cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter: one decrement per prescaled tick, one-cycle done_pulse at zero.
// load_ready only in IDLE (loads elsewhere dropped); COUNTDOWN_TIMER_AUTORELOAD_EN makes it periodic.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] current_count,
    output logic             busy,
    output logic             done_pulse
);

    state_t state, state_nxt;
    logic   tick;
    logic   presc_en;
    logic   presc_clr;
    logic   load_acc;
    logic   reload_go;

    assign load_acc  = load_valid && (state == IDLE);
    assign presc_en  = (state == RUN) && !pause;
    // Holding the prescaler cleared outside RUN gives every run a fresh phase.
    assign presc_clr = abort || (state != RUN);

    countdown_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (presc_en),
        .clear  (presc_clr),
        .tick   (tick)
    );

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_q <= '0;
        end else if (load_acc && !abort) begin
            reload_q <= load_value;
        end
    end

    assign reload_go = (state == DONE) && (reload_q != '0);
`else
    assign reload_go = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (load_valid) state_nxt = (load_value != '0) ? RUN : DONE;
            RUN:  if (tick && (current_count == WIDTH'(1))) state_nxt = DONE;
            DONE: state_nxt = reload_go ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_comb begin
        load_ready = (state == IDLE);
        busy       = (state == RUN);
        done_pulse = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            current_count <= '0;
        end else if (abort) begin
            current_count <= '0;
        end else if (load_acc) begin
            current_count <= load_value;
        end else if (tick && (current_count != '0)) begin
            current_count <= current_count - WIDTH'(1);
        end else if (reload_go) begin
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            current_count <= reload_q;
`else
            current_count <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: PRESCALE=1 and PRESCALE=4 instances on one clock.
// Periodic-reload checks are included when COUNTDOWN_TIMER_AUTORELOAD_EN is defined.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       lval1 = 1'b0, pause1 = 1'b0, abort1 = 1'b0;
    logic [7:0] lv1 = '0;
    logic       ready1, busy1, done1;
    logic [7:0] cc1;

    logic       lval4 = 1'b0, pause4 = 1'b0, abort4 = 1'b0;
    logic [7:0] lv4 = '0;
    logic       ready4, busy4, done4;
    logic [7:0] cc4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(8), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .load_valid(lval1), .load_ready(ready1),
        .load_value(lv1), .pause(pause1), .abort(abort1),
        .current_count(cc1), .busy(busy1), .done_pulse(done1)
    );

    countdown_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .load_valid(lval4), .load_ready(ready4),
        .load_value(lv4), .pause(pause4), .abort(abort4),
        .current_count(cc4), .busy(busy4), .done_pulse(done4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_done;
        int done_cnt;

        // Reset values
        #12;
        chk("rst_ready", 32'(ready1), 1);
        chk("rst_busy",  32'(busy1), 0);
        chk("rst_done",  32'(done1), 0);
        chk("rst_count", 32'(cc1), 0);
        chk("rst_count4", 32'(cc4), 0);
        @(posedge clk);
        #1 rst = 1'b0;

`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
        // Load 5, PRESCALE 1: 5,4,3,2,1,0 then DONE one cycle, then IDLE
        lval1 = 1'b1; lv1 = 8'd5;
        step();
        lval1 = 1'b0;
        chk("l5_count0", 32'(cc1), 5);
        chk("l5_busy",   32'(busy1), 1);
        chk("l5_ready",  32'(ready1), 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("l5_count", 32'(cc1), 32'(5 - k));
            chk("l5_nodone", 32'(done1), 0);
        end
        step();
        chk("l5_zero",  32'(cc1), 0);
        chk("l5_done",  32'(done1), 1);
        chk("l5_idle_busy", 32'(busy1), 0);
        chk("l5_ready_lo", 32'(ready1), 0);
        step();
        chk("l5_done_off", 32'(done1), 0);
        chk("l5_ready_hi", 32'(ready1), 1);
`endif

        // Zero load: DONE next edge, IDLE one later
        lval1 = 1'b1; lv1 = 8'd0;
        step();
        lval1 = 1'b0;
        chk("z_done",  32'(done1), 1);
        chk("z_count", 32'(cc1), 0);
        chk("z_ready", 32'(ready1), 0);
        step();
        chk("z_done_off", 32'(done1), 0);
        chk("z_ready_hi", 32'(ready1), 1);

        // Load 10, abort on the cycle count==1 with a tick pending
        lval1 = 1'b1; lv1 = 8'd10;
        step();
        lval1 = 1'b0;
        for (int k = 0; k < 9; k++) step();
        chk("ab_count1", 32'(cc1), 1);
        abort1 = 1'b1;
        step();
        abort1 = 1'b0;
        chk("ab_count", 32'(cc1), 0);
        chk("ab_ready", 32'(ready1), 1);
        chk("ab_done",  32'(done1), 0);
        chk("ab_busy",  32'(busy1), 0);
        step();
        chk("ab_done2", 32'(done1), 0);

`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
        // load_valid held through RUN: next load only on first IDLE edge
        lval1 = 1'b1; lv1 = 8'd2;
        step();
        lv1 = 8'd7;
        chk("hv_count2", 32'(cc1), 2);
        step();
        chk("hv_count1", 32'(cc1), 1);
        step();
        chk("hv_done", 32'(done1), 1);
        chk("hv_zero", 32'(cc1), 0);
        step();
        chk("hv_idle", 32'(ready1), 1);
        chk("hv_notqueued", 32'(cc1), 0);
        step();
        lval1 = 1'b0;
        chk("hv_reload", 32'(cc1), 7);
        chk("hv_busy",   32'(busy1), 1);
        abort1 = 1'b1;
        step();
        abort1 = 1'b0;
        chk("hv_abort_ready", 32'(ready1), 1);
`endif

        // PRESCALE 4, load 3, 5 paused cycles: done 17 cycles after acceptance
        lval4 = 1'b1; lv4 = 8'd3;
        step();
        lval4 = 1'b0;
        chk("p4_count0", 32'(cc4), 3);
        first_done = -1;
        done_cnt = 0;
        for (int i = 1; i <= 25; i++) begin
            pause4 = (i >= 5 && i <= 9);
            step();
            if (i == 4) chk("p4_count_tick1", 32'(cc4), 2);
            if (i == 8) chk("p4_count_paused", 32'(cc4), 2);
            if (done4 && first_done < 0) first_done = i;
            if (done4) done_cnt++;
        end
        pause4 = 1'b0;
        chk("p4_first_done", 32'(first_done), 17);
`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
        chk("p4_done_cnt", 32'(done_cnt), 1);
        chk("p4_ready", 32'(ready4), 1);
`endif
        abort4 = 1'b1;
        step();
        abort4 = 1'b0;
        chk("p4_abort_ready", 32'(ready4), 1);

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        // Load 3 periodic: done_pulse every 4 cycles, abort stops it
        lval1 = 1'b1; lv1 = 8'd3;
        step();
        lval1 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("ar_done", 32'(done1), 32'((i % 4) == 3));
            chk("ar_ready_lo", 32'(ready1), 0);
        end
        abort1 = 1'b1;
        step();
        abort1 = 1'b0;
        chk("ar_abort_ready", 32'(ready1), 1);
        chk("ar_abort_count", 32'(cc1), 0);
        step();
        chk("ar_abort_done", 32'(done1), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
